ycbcr_src_sched: RTL and testbench

//  Frame-level scheduler sharing the single RGB565->YCbCr conversion pipeline between two

---
 rtl/ycbcr_src_sched.sv | 130 +++++++++++++
 tb/tb_ycbcr_src_sched.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ycbcr_src_sched.sv
// ycbcr_src_sched: frame-level arbiter sharing one RGB565->YCbCr converter between two sources
// Ports: clk, rst_n (async, active low); s0_*/s1_* vsync/hsync/de/rgb source inputs;
//   sel_req requested source; pipe_* converter feed; cur_src granted source; out_src grant
//   aligned to converter output; busy while draining or waiting for start of frame;
//   frame_done end-of-frame pulse; frame_width/frame_height geometry of last forwarded frame.
module ycbcr_src_sched #(
  parameter int PIPE_LAT = 3,
  parameter int H_W      = 12,
  parameter int V_W      = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s0_vsync,
  input  logic           s0_hsync,
  input  logic           s0_de,
  input  logic [15:0]    s0_rgb,
  input  logic           s1_vsync,
  input  logic           s1_hsync,
  input  logic           s1_de,
  input  logic [15:0]    s1_rgb,
  input  logic           sel_req,
  output logic           pipe_vsync,
  output logic           pipe_hsync,
  output logic           pipe_de,
  output logic [15:0]    pipe_rgb,
  output logic           cur_src,
  output logic           out_src,
  output logic           busy,
  output logic           frame_done,
  output logic [H_W-1:0] frame_width,
  output logic [V_W-1:0] frame_height
);
  typedef enum logic [1:0] {IDLE, WAIT_SOF, RUN, DRAIN} state_t;
  localparam int DW = $clog2(PIPE_LAT + 1);
  state_t state;
  logic tgt, s0_vs_q, s1_vs_q, pipe_de_q, src, sv, sh, sd, rise, de_fall;
  logic [15:0] srgb;
  logic [H_W-1:0] hcnt, hcnt_nxt, line_w, line_nxt;
  logic [V_W-1:0] vcnt, vcnt_nxt;
  logic [DW-1:0] dcnt;
  logic [PIPE_LAT-1:0] src_sr;
  // Before the grant is confirmed in RUN, the pending target is the only source watched.
  always_comb begin
    src      = state == RUN ? cur_src : tgt;
    sv       = src ? s1_vsync : s0_vsync;
    sh       = src ? s1_hsync : s0_hsync;
    sd       = src ? s1_de : s0_de;
    srgb     = src ? s1_rgb : s0_rgb;
    rise     = sv & ~(src ? s1_vs_q : s0_vs_q);
    de_fall  = pipe_de_q & ~pipe_de;
    hcnt_nxt = de_fall ? '0 : hcnt + H_W'(pipe_de & ~&hcnt);
    line_nxt = de_fall ? hcnt : line_w;
    vcnt_nxt = vcnt + V_W'(de_fall & ~&vcnt);
  end
  assign busy    = state == DRAIN || state == WAIT_SOF;
  assign out_src = src_sr[PIPE_LAT-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tgt          <= 1'b0;
      cur_src      <= 1'b0;
      s0_vs_q      <= 1'b0;
      s1_vs_q      <= 1'b0;
      pipe_de_q    <= 1'b0;
      pipe_vsync   <= 1'b0;
      pipe_hsync   <= 1'b0;
      pipe_de      <= 1'b0;
      pipe_rgb     <= '0;
      frame_done   <= 1'b0;
      frame_width  <= '0;
      frame_height <= '0;
      hcnt         <= '0;
      vcnt         <= '0;
      line_w       <= '0;
      dcnt         <= '0;
      src_sr       <= '0;
    end else begin
      s0_vs_q    <= s0_vsync;
      s1_vs_q    <= s1_vsync;
      pipe_de_q  <= pipe_de;
      src_sr     <= PIPE_LAT'({src_sr, cur_src});
      frame_done <= 1'b0;
      {pipe_vsync, pipe_hsync, pipe_de, pipe_rgb} <= '0;
      case (state)
        IDLE: begin
          tgt   <= sel_req;
          state <= WAIT_SOF;
        end
        WAIT_SOF: begin
          cur_src <= tgt;
          hcnt    <= '0;
          vcnt    <= '0;
          line_w  <= '0;
          if (rise) begin
            state <= RUN;
            {pipe_vsync, pipe_hsync, pipe_de, pipe_rgb} <= {sv, sh, sd, srgb};
          end
        end
        RUN: begin
          if (rise) begin
            // A line ending on the boundary cycle is folded into the reported geometry.
            frame_done   <= 1'b1;
            frame_width  <= line_nxt;
            frame_height <= vcnt_nxt;
            hcnt         <= '0;
            vcnt         <= '0;
            line_w       <= '0;
            if (sel_req == cur_src) begin
              {pipe_vsync, pipe_hsync, pipe_de, pipe_rgb} <= {sv, sh, sd, srgb};
            end else begin
              tgt   <= sel_req;
              dcnt  <= '0;
              state <= DRAIN;
            end
          end else begin
            {pipe_vsync, pipe_hsync, pipe_de, pipe_rgb} <= {sv, sh, sd, srgb};
            hcnt   <= hcnt_nxt;
            line_w <= line_nxt;
            vcnt   <= vcnt_nxt;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + DW'(1);
          if (dcnt == DW'(PIPE_LAT - 1)) state <= WAIT_SOF;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ycbcr_src_sched.sv
// tb_ycbcr_src_sched: directed scoreboard bench for the two-source converter scheduler
module tb_ycbcr_src_sched;
  logic clk = 1'b0, rst_n;
  logic s0_vsync, s0_hsync, s0_de, s1_vsync, s1_hsync, s1_de, sel_req;
  logic [15:0] s0_rgb, s1_rgb, pipe_rgb;
  logic pipe_vsync, pipe_hsync, pipe_de, cur_src, out_src, busy, frame_done;
  logic [11:0] frame_width;
  logic [10:0] frame_height;
  logic [19:0] q[$];
  int vec = 0, miss = 0;
  ycbcr_src_sched dut (
    .clk(clk), .rst_n(rst_n),
    .s0_vsync(s0_vsync), .s0_hsync(s0_hsync), .s0_de(s0_de), .s0_rgb(s0_rgb),
    .s1_vsync(s1_vsync), .s1_hsync(s1_hsync), .s1_de(s1_de), .s1_rgb(s1_rgb),
    .sel_req(sel_req),
    .pipe_vsync(pipe_vsync), .pipe_hsync(pipe_hsync), .pipe_de(pipe_de), .pipe_rgb(pipe_rgb),
    .cur_src(cur_src), .out_src(out_src), .busy(busy), .frame_done(frame_done),
    .frame_width(frame_width), .frame_height(frame_height)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_pipe"}, 32'({pipe_vsync, pipe_hsync, pipe_de, pipe_rgb}), 0);
    chk({tag, "_cur"}, 32'(cur_src), 0);
    chk({tag, "_out"}, 32'(out_src), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(frame_done), 0);
    chk({tag, "_w"}, 32'(frame_width), 0);
    chk({tag, "_h"}, 32'(frame_height), 0);
  endtask
  // One cycle: compare last cycle's expectation, drive new inputs, queue what the pipe must show next.
  // fwd: 0 = s0 forwarded, 1 = s1 forwarded, 2 = pipe held zero
  task automatic cyc(input logic [18:0] a, input logic [18:0] b, input int fwd, input logic fd);
    logic [19:0] e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      vec++;
      assert ({frame_done, pipe_vsync, pipe_hsync, pipe_de, pipe_rgb} === e) else begin
        miss++;
        $error("FAIL pipe observed=%h expected=%h",
               {frame_done, pipe_vsync, pipe_hsync, pipe_de, pipe_rgb}, e);
      end
    end
    {s0_vsync, s0_hsync, s0_de, s0_rgb} = a;
    {s1_vsync, s1_hsync, s1_de, s1_rgb} = b;
    q.push_back({fd, fwd == 0 ? a : fwd == 1 ? b : 19'd0});
  endtask
  // mode 1: noise on the other source and a mid-frame sel_req flip; mode 2: drain checks
  task automatic frame(input int s, input int lines, input int w, input int fwd0, input int fwd,
                       input logic done, input int ew, input int eh, input int mode);
    int n;
    logic [18:0] x, o;
    n = 3 + lines * (w + 2);
    for (int c = 0; c < n; c++) begin
      if (c < 2) x = 19'h40000;
      else if (c == 2) x = '0;
      else begin
        int p;
        p = (c - 3) % (w + 2);
        x = p == 0 ? 19'h20000 : p <= w ? {3'b001, 16'($urandom)} : 19'd0;
      end
      o = mode == 1 ? 19'($urandom) : 19'd0;
      cyc(s != 0 ? o : x, s != 0 ? x : o, c == 0 ? fwd0 : fwd, c == 0 && done);
      if (c == 1 && done) begin
        chk("width", 32'(frame_width), ew);
        chk("height", 32'(frame_height), eh);
      end
      if (mode == 1 && c == n / 2) sel_req = 1'b1;
      if (mode == 2) begin
        if (c >= 1 && c <= 3) chk("drain_busy", 32'(busy), 1);
        if (c == 4) chk("drain_cur0", 32'(cur_src), 0);
        if (c == 5) chk("wait_cur1", 32'(cur_src), 1);
        if (c == 7) chk("out_src0", 32'(out_src), 0);
        if (c == 8) chk("out_src1", 32'(out_src), 1);
        if (c == 1 || c == 3) sel_req = 1'b0;
        if (c == 2) sel_req = 1'b1;
      end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    sel_req = 1'b0;
    {s0_vsync, s0_hsync, s0_de, s0_rgb} = '0;
    {s1_vsync, s1_hsync, s1_de, s1_rgb} = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (3) cyc('0, '0, 2, 1'b0);
    chk("busy_wait_sof", 32'(busy), 1);
    frame(0, 3, 4, 0, 0, 1'b0, 0, 0, 0);
    frame(0, 3, 4, 0, 0, 1'b1, 4, 3, 1);
    chk("cur_src_hold", 32'(cur_src), 0);
    chk("out_src_s0", 32'(out_src), 0);
    frame(0, 3, 4, 2, 2, 1'b1, 4, 3, 2);
    frame(0, 2, 2, 2, 2, 1'b0, 0, 0, 0);
    sel_req = 1'b1;
    frame(1, 2, 3, 1, 1, 1'b0, 0, 0, 0);
    chk("run_cur_s1", 32'(cur_src), 1);
    chk("run_out_s1", 32'(out_src), 1);
    chk("run_busy", 32'(busy), 0);
    frame(1, 1, 5000, 1, 1, 1'b1, 3, 2, 0);
    frame(1, 1, 2, 1, 1, 1'b1, 4095, 1, 0);
    repeat (2) cyc('0, {3'b001, 16'h1234}, 1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    q.delete();
    repeat (2) cyc('0, '0, 2, 1'b0);
    rst_n = 1'b1;
    repeat (3) cyc('0, '0, 2, 1'b0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_no_done", 32'(frame_done), 0);
    frame(1, 2, 2, 1, 1, 1'b0, 0, 0, 0);
    frame(1, 1, 2, 1, 1, 1'b1, 2, 2, 0);
    repeat (2) cyc('0, '0, 1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
